// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the receiver and transmitter state encodings and the frame data width
// so both ends of the link agree on them. No ports; import with uart_pkg::*.
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Receiver FSM encoding.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Transmitter FSM encoding.
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-delivery channel from the UART receiver to the consuming logic.
//   data_out   : received byte, stable while data_valid=1
//   data_valid : holding register full
//   data_ready : consumer can take the byte
// Handshake: data_out is presented with data_valid=1 and held unchanged until a
// rising clock edge with data_valid & data_ready, which is the one transfer of
// that byte. data_valid never drops without a transfer (except on reset).
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
//   clk      : destination clock
//   reset_n  : asynchronous active-low reset, both flops load RESET_VAL
//   d        : asynchronous input
//   q        : synchronized output, two clocks of latency
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver.
// Oversamples rx at CLKS_PER_BIT clocks per bit, samples each bit at mid-bit,
// and places good bytes in a one-entry holding register offered on bus.
//   clk        : system clock, all state on rising edge
//   reset_n    : asynchronous active-low reset
//   rx         : raw serial line, asynchronous, idle high
//   bus        : byte channel (data_out / data_valid / data_ready)
//   frame_err  : one-cycle pulse when the stop bit is sampled low
//   overrun    : sticky; a good byte was dropped because the register was full
//   busy       : registered, high whenever the FSM is not in IDLE
//   state_dbg  : current FSM state
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      rx,
  uart_rx_if.master bus,
  output logic      frame_err,
  output logic      overrun,
  output logic      busy,
  output rx_state_e state_dbg
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  if ((CLKS_PER_BIT % 2) != 0 || CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
    $error("uart_rx: CLKS_PER_BIT must be even and at least 4");
  end

  logic                 rx_s;
  rx_state_e            state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [DATA_BITS-1:0] sh, sh_nx;
  logic [2:0]           idx, idx_nx;
  logic                 deliver;
  logic                 stop_bad;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sh    <= sh_nx;
      idx   <= idx_nx;
    end
  end

  // Next state. The counter free-runs inside a state and is forced to zero on
  // every transition, so each state measures time from its own entry.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + CW'(1);
    sh_nx    = sh;
    idx_nx   = idx;
    deliver  = 1'b0;
    stop_bad = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!rx_s) state_nx = START;
      end

      START: begin
        // Mid start bit: a line already back high was a glitch, drop silently.
        if (cnt == CNT_HALF) begin
          cnt_nx = '0;
          idx_nx = '0;
          state_nx = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          sh_nx  = {rx_s, sh[DATA_BITS-1:1]};
          if (idx == IDX_LAST) state_nx = STOP;
          else                 idx_nx   = idx + 3'd1;
        end
      end

      STOP: begin
        // Leaving at mid-stop lets the next start edge follow with no gap.
        if (cnt == CNT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            deliver  = 1'b1;
            state_nx = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_nx = BREAK;
          end
        end
      end

      BREAK: begin
        // Hold here while the line stays low so a break is one error, not many.
        cnt_nx = '0;
        if (rx_s) state_nx = IDLE;
      end

      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  // Holding register, status flags. A delivery that coincides with a transfer
  // of the old byte reloads the register instead of counting as an overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      busy      <= (state_nx != IDLE);
      if (deliver) begin
        if (!valid_q || bus.data_ready) begin
          data_q  <= sh;
          valid_q <= 1'b1;
          overrun <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_q && bus.data_ready) begin
        valid_q <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign state_dbg      = state;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver paired with the team's UART transmitter, the downstream stage that consumes its `tx` line. It oversamples the asynchronous `rx` input at CLKS_PER_BIT clocks per bit and recovers 8N1 frames (start bit low, 8 data bits LSB first, stop bit high). Each received byte goes into a one-entry holding register with a valid/ready handshake toward the consuming logic. It flags framing errors and overruns.

## Interface
- CLKS_PER_BIT, 8, clocks per bit period; must be even and ≥ 4 (elaboration assertion); HALF = CLKS_PER_BIT/2
- clk  in  1  single system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- rx  in  1  raw serial line, asynchronous to clk, idle high
- data_out  out  8  received byte; stable while data_valid=1
- data_valid  out  1  holding register full
- data_ready  in  1  consumer accepts byte when data_valid & data_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  sticky; set when a good frame completes while data_valid=1; cleared by a handshake
- busy  out  1  high in any state other than IDLE

## Operation
- rx passes through a 2-flop synchronizer (reset value 1) to give rx_s. All decisions use rx_s.
- bit counter cnt is $clog2(CLKS_PER_BIT) bits wide. It is zeroed on every state entry, and it is also zeroed on wrap in DATA/STOP.
- Shift register sh[7:0] shifts right and inserts the sampled bit at sh[7]. The bit index idx[2:0] counts 0..7 with no wrap past 7.
- FSM states:
  - IDLE: rx_s=0 → START.
  - START: at cnt==HALF-1, if rx_s=1 → IDLE (glitch, nothing reported); else → DATA.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rx_s into sh, idx++. Leave when idx==7 on the sample → STOP.
  - STOP: at cnt==CLKS_PER_BIT-1:
    - rx_s=1 → IDLE and deliver.
    - rx_s=0 → frame_err pulse, discard byte, → BREAK.
  - BREAK: wait for rx_s=1 → IDLE, so a held-low line is not re-triggered.
- Deliver:
  - If data_valid=0: data_out←sh, data_valid←1.
  - If data_valid=1 and the consumer does not hand-shake in the same cycle: keep the old byte, set overrun, drop the new byte.
  - If data_valid=1 and data_ready=1 in the delivery cycle: the handshake and the load both happen. The new byte loads, data_valid stays 1, no overrun.
- Handshake: data_valid & data_ready clears data_valid and overrun (unless the same-cycle load above applies).
- Reset (any time, including mid-frame): state=IDLE, cnt=0, sh=0, idx=0, data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, sync flops=1.

## Timing
- Edge 0 is the first clk edge that captures rx=0 into sync stage 1.
  - rx_s=0 at edge 1; START entered at edge 2.
  - Start-bit check at edge 2+HALF.
  - Data bit i sampled at edge 2+HALF+(i+1)·CLKS_PER_BIT.
  - Stop sampled at edge 2+HALF+9·CLKS_PER_BIT. data_valid or frame_err is visible after that edge (edge 78 for CLKS_PER_BIT=8).
- Sampling lands at mid-bit, giving a ±HALF-1 clock tolerance to edge skew.
- Returning to IDLE at mid-stop allows back-to-back frames from the transmitter with no idle gap.
- frame_err is exactly one cycle wide. busy is registered from state.

## Structure
- Shared package uart_pkg:
  - rx state enum (IDLE, START, DATA, STOP, BREAK) as logic[2:0]
  - DATA_BITS=8
  - Transmitter states move there as well.
- One sub-module: sync_2ff (parameterized reset value), reusable for other async inputs.
- Everything else stays in uart_rx.

## Test plan
- Loopback from the transmitter (CLKS_PER_BIT=8), byte 0xA5, data_ready=1 → data_valid pulses with data_out=0xA5 at edge 78; frame_err=0, overrun=0.
- rx low for 3 clocks, then high → no data_valid, no frame_err; busy drops to 0 by edge 2+HALF+1.
- Frame 0x3C with stop bit driven low, line held low for 40 clocks → frame_err one-cycle pulse; busy stays high until rx returns high; no data_valid.
- Back-to-back 0x11, 0x22 with data_ready=0 → data_out=0x11 held, overrun=1. Then assert data_ready for one cycle → data_valid=0, overrun=0.
- Delivery of 0x55 coincident with a handshake of 0xAA → data_out=0x55, data_valid=1, overrun=0.
- reset_n pulsed low at DATA bit 4 of 0xF0 → all outputs 0 (busy=0) immediately. A following 0x0F frame is received correctly.
